// File: rtl/lsu_pkg.sv
// Shared types and lane constants for the load/store unit.
// Size encodings, FSM states and big-endian lane positions live here.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Big-endian lanes: the lowest byte address holds the most significant bits.
  localparam logic [4:0] LANE_B0_LSB = 5'd24;
  localparam logic [4:0] LANE_B1_LSB = 5'd16;
  localparam logic [4:0] LANE_B2_LSB = 5'd8;
  localparam logic [4:0] LANE_B3_LSB = 5'd0;
  localparam logic [4:0] LANE_H0_LSB = 5'd16;
  localparam logic [4:0] LANE_H2_LSB = 5'd0;

  function automatic logic [4:0] byte_lsb(input logic [1:0] off);
    case (off)
      2'd0:    return LANE_B0_LSB;
      2'd1:    return LANE_B1_LSB;
      2'd2:    return LANE_B2_LSB;
      default: return LANE_B3_LSB;
    endcase
  endfunction

  function automatic logic [4:0] half_lsb(input logic off_hi);
    return off_hi ? LANE_H2_LSB : LANE_H0_LSB;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction/extension for loads and lane merge for
// sub-word stores; word accesses pass data straight through.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [4:0]  w_lsb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_lsb    = (i_size == SZ_HALF) ? half_lsb(i_off[1]) : byte_lsb(i_off);
    w_byte   = 8'(i_word >> w_lsb);
    w_half   = 16'(i_word >> w_lsb);
    o_rdata  = i_word;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_rdata  = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_merged = (i_word & ~(32'h0000_00FF << w_lsb)) | ({24'h0, i_wdata[7:0]} << w_lsb);
      end
      SZ_HALF: begin
        o_rdata  = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        o_merged = (i_word & ~(32'h0000_FFFF << w_lsb)) | ({16'h0, i_wdata[15:0]} << w_lsb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, read-modify-write for
// sub-word stores. Define LSU_ALIGN_CHECK_EN to reject misaligned accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read_control,
  output logic        write_data_control,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  o_dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no backpressure.

  lsu_state_e r_state, w_next;
  logic        r_we, r_unsigned, r_err;
  lsu_size_e   r_size;
  logic [31:0] r_addr, r_wdata, r_word;

  lsu_size_e   w_size;
  logic [31:0] w_addr;
  logic        w_misaligned, w_oor, w_err, w_accept;
  logic [31:0] w_rdata, w_merged;

  assign w_size = (req_size == SZ_RSVD) ? SZ_WORD : lsu_size_e'(req_size);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_addr       = req_addr;
  assign w_misaligned = ((w_size == SZ_HALF) && req_addr[0]) ||
                        ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  // Misaligned accesses are silently rounded down to the natural boundary.
  assign w_addr       = (w_size == SZ_WORD) ? {req_addr[31:2], 2'b00} :
                        (w_size == SZ_HALF) ? {req_addr[31:1], 1'b0}  : req_addr;
  assign w_misaligned = 1'b0;
`endif

  assign w_oor    = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign w_err    = w_oor || w_misaligned;
  assign w_accept = req_valid && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_err      <= w_err;
        r_size     <= w_size;
        r_addr     <= w_addr;
        r_wdata    <= req_wdata;
      end
      if (r_state == ST_READ) r_word <= mem_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_err)                               w_next = ST_RESP;
          else if (req_we && (w_size == SZ_WORD))  w_next = ST_WRITE;
          else                                     w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      default:  w_next = ST_IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .i_word     (r_word),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .o_rdata    (w_rdata),
    .o_merged   (w_merged)
  );

  always_comb begin
    req_ready          = (r_state == ST_IDLE);
    mem_read_control   = (r_state == ST_READ);
    // Gating with rst_n keeps a reset that lands mid-write from corrupting memory.
    write_data_control = (r_state == ST_WRITE) && rst_n;
    mem_addr           = 32'h0;
    mem_wdata          = 32'h0;
    if ((r_state == ST_READ) || (r_state == ST_WRITE)) mem_addr = {2'b00, r_addr[31:2]};
    if (r_state == ST_WRITE) mem_wdata = w_merged;
    resp_valid = (r_state == ST_RESP);
    resp_err   = (r_state == ST_RESP) && r_err;
    resp_rdata = ((r_state == ST_RESP) && !r_we && !r_err) ? w_rdata : 32'h0;
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized traffic
// compared against a byte-array reference model of memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int MW = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_read_control, write_data_control;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  lsu_state_e  dbg_state;

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_idx = 7'd0;
  logic [31:0] pl_data = 32'h0;
  int          rd_cnt = 0, wr_cnt = 0;
  int          n_checks = 0, n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_read_control(mem_read_control), .write_data_control(write_data_control),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // Memory model: combinational read, write on rising edge, bench-side preload port.
  assign mem_rdata = (mem_addr < 32'(MW)) ? mem[mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_read_control) rd_cnt <= rd_cnt + 1;
    if (write_data_control) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 32'(MW)) mem[mem_addr[6:0]] <= mem_wdata;
    end
    if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 7'(idx); pl_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Reference: memory as big-endian bytes, access width 1/2/4, expected latency and strobes.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_rd, output logic exp_err, output int exp_lat,
                       output int exp_rds, output int exp_wrs);
    int nbytes, sh, idx;
    logic [31:0] a, w, v, mask;
    a = addr;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_rd = 32'h0; exp_err = 1'b0; exp_rds = 0; exp_wrs = 0; exp_lat = 1;
`ifdef LSU_ALIGN_CHECK_EN
    if ((a % nbytes) != 0) exp_err = 1'b1;
`else
    a = a - (a % nbytes);
`endif
    if ((a >> 2) >= 32'(MW)) exp_err = 1'b1;
    if (exp_err) return;
    idx  = int'(a >> 2);
    w    = ref_mem[idx];
    sh   = 8 * (4 - int'(a[1:0]) - nbytes);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    if (!we) begin
      v = (w >> sh) & mask;
      if (!uns && (nbytes < 4) && v[8 * nbytes - 1]) v = v | ~mask;
      exp_rd = v; exp_lat = 2; exp_rds = 1;
    end else begin
      ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      exp_wrs = 1;
      exp_rds = (nbytes < 4) ? 1 : 0;
      exp_lat = (nbytes < 4) ? 3 : 2;
    end
  endtask

  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] act_rd);
    logic [31:0] exp_rd, exp_pop;
    logic        exp_err, act_err, got;
    int          exp_lat, exp_rds, exp_wrs, lat, rd0, wr0, idx;
    model(we, size, uns, addr, wdata, exp_rd, exp_err, exp_lat, exp_rds, exp_wrs);
    exp_q.push_back(exp_rd);
    @(negedge clk);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Scramble request fields after acceptance; the DUT must ignore them.
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;
    got = 1'b0; lat = 0; act_rd = 32'h0; act_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin
        got = 1'b1; lat = k; act_rd = resp_rdata; act_err = resp_err;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    exp_pop = exp_q.pop_front();
    check_eq("resp_seen", 32'(got), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_err", 32'(act_err), 32'(exp_err));
    check_eq("resp_rdata", act_rd, exp_pop);
    check_eq("read_strobes", 32'(rd_cnt - rd0), 32'(exp_rds));
    check_eq("write_strobes", 32'(wr_cnt - wr0), 32'(exp_wrs));
    @(negedge clk);
    check_eq("resp_pulse", 32'(resp_valid), 32'd0);
    idx = int'(addr >> 2);
    if (idx < MW) check_eq("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] rd, a;
    int          wr0;

    // Reset held while memory is preloaded; outputs must sit at reset values.
    for (int i = 0; i < MW; i++) preload(i, $urandom);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_strobes", 32'({mem_read_control, write_data_control}), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    preload(2, 32'd5);
    do_txn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd);
    check_eq("lw_0x8", rd, 32'h0000_0005);

    preload(0, 32'h1234_80FF);
    do_txn(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, rd);
    check_eq("lb_0x2", rd, 32'hFFFF_FF80);
    do_txn(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, rd);
    check_eq("lbu_0x2", rd, 32'h0000_0080);
    do_txn(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, rd);
    check_eq("lh_0x2", rd, 32'hFFFF_80FF);

    preload(1, 32'h1111_1111);
    do_txn(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, rd);
    check_eq("sb_0x5_word", mem[1], 32'h11AB_1111);

    do_txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd);
`ifndef LSU_ALIGN_CHECK_EN
    check_eq("lw_0x6_aligned", rd, 32'h11AB_1111);
`endif
    do_txn(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, rd);
    do_txn(1'b0, 2'b11, 1'b0, 32'h1FC, 32'h0, rd);
    do_txn(1'b1, 2'b01, 1'b0, 32'h1FE, 32'h0000_BEEF, rd);

    // Reset arriving during the WRITE cycle of a byte store.
    preload(3, 32'hCAFE_BABE);
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'hD; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rmw_read_phase", 32'(mem_read_control), 32'd1);
    @(negedge clk);
    check_eq("rmw_write_state", 32'(dbg_state), 32'(ST_WRITE));
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_write_strobe", 32'(write_data_control), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mid_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    check_eq("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
    check_eq("rst_mid_mem", mem[3], 32'hCAFE_BABE);

    // Randomized traffic, mostly in range with occasional out-of-range addresses.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(MW * 4, 4095));
      else
        a = 32'($urandom_range(0, MW * 4 - 1));
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
